hmac_stream_arbiter: RTL

//  Shares one HMAC core (512-bit AXI4-Stream in, one digest beat per packet out) between N_REQ requester streams.

---
 rtl/hmac_arb_pkg.sv | 38 +++
 rtl/hmac_stream_arbiter_fifo.sv | 63 ++++++
 rtl/hmac_stream_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hmac_arb_pkg.sv
// Shared types and helpers for the HMAC stream arbiter.
//   DATA_W / KEEP_W / ID_W : AXI4-Stream widths of the HMAC core interface
//   state_t                : arbiter FSM states
//   tag_t                  : requester index stored in the in-order tag FIFO
//   rr_pick                : round-robin selection helper
package hmac_arb_pkg;

    localparam int DATA_W    = 512;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int ID_W      = 6;
    // Tags are sized for the largest supported requester count so one
    // package serves every N_REQ in 2..8.
    localparam int N_REQ_MAX = 8;
    localparam int TAG_W     = $clog2(N_REQ_MAX);

    typedef enum logic {IDLE, PASS} state_t;
    typedef logic [TAG_W-1:0] tag_t;

    // First set bit of req strictly after ptr, searching upward and wrapping
    // within n requesters. Returns ptr when nothing is requesting.
    function automatic tag_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                     input tag_t ptr, input int n);
        tag_t pick;
        tag_t idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ_MAX; i++) begin
            idx = tag_t'((int'(ptr) + i) % n);
            if (i <= n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hmac_stream_arbiter_fifo.sv
// hmac_tag_fifo: synchronous FIFO of requester tags with first-word
// fall-through head.
//   aclk, areset : clock, asynchronous active-low reset
//   push, din    : write a tag (ignored while full)
//   pop          : drop the head tag (ignored while empty)
//   head         : current oldest tag, valid while !empty
//   full, empty  : occupancy flags
//   count        : number of stored tags (0..DEPTH)
module hmac_tag_fifo
    import hmac_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  tag_t                     din,
    input  logic                     pop,
    output tag_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Tag storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/hmac_stream_arbiter.sv
// hmac_stream_arbiter: shares one HMAC core between N_REQ requester streams.
// Packets are granted round-robin, whole packet at a time, and each digest is
// routed back to the requester whose packet produced it via an in-order tag
// FIFO.
//   aclk, areset           : clock, asynchronous active-low reset
//   s_req_*                : N_REQ packed requester AXI4-Stream inputs
//   m_core_*               : muxed stream to the HMAC core
//   s_res_*                : digest beat from the HMAC core
//   m_res_tvalid/tready    : per-requester digest handshake (one-hot valid)
//   m_res_tdata            : digest, shared by all requesters
//   inflight               : packets in the core awaiting a digest
//   err_orphan             : sticky, digest seen with nothing in flight
// Optional build macro HMAC_ARB_STATS_EN adds pkt_cnt (per-requester tlast
// handshake counters, wrapping) and stall_cnt (IDLE cycles blocked by a full
// tag FIFO, saturating).
module hmac_stream_arbiter
    import hmac_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [N_REQ-1:0]                  s_req_tvalid,
    output logic [N_REQ-1:0]                  s_req_tready,
    input  logic [N_REQ*DATA_W-1:0]           s_req_tdata,
    input  logic [N_REQ*KEEP_W-1:0]           s_req_tkeep,
    input  logic [N_REQ*ID_W-1:0]             s_req_tid,
    input  logic [N_REQ-1:0]                  s_req_tlast,
    output logic                              m_core_tvalid,
    input  logic                              m_core_tready,
    output logic [DATA_W-1:0]                 m_core_tdata,
    output logic [KEEP_W-1:0]                 m_core_tkeep,
    output logic [ID_W-1:0]                   m_core_tid,
    output logic                              m_core_tlast,
    input  logic                              s_res_tvalid,
    output logic                              s_res_tready,
    input  logic [DATA_W-1:0]                 s_res_tdata,
    output logic [N_REQ-1:0]                  m_res_tvalid,
    input  logic [N_REQ-1:0]                  m_res_tready,
    output logic [DATA_W-1:0]                 m_res_tdata,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight,
    output logic                              err_orphan
`ifdef HMAC_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]               pkt_cnt,
    output logic [31:0]                       stall_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    tag_t             grant;
    tag_t             grant_nxt;
    tag_t             rr_ptr;
    tag_t             rr_ptr_nxt;
    tag_t             pick;
    tag_t             head;
    logic [N_REQ-1:0] head_oh;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign pick = rr_pick(N_REQ_MAX'(s_req_tvalid), rr_ptr, N_REQ);

    hmac_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (push),
        .din    (pick),
        .pop    (pop),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (inflight)
    );

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= tag_t'(N_REQ - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // IDLE spends one cycle choosing and tagging the next packet; PASS is a
    // zero-latency combinational path from the granted requester to the core.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        push          = 1'b0;
        s_req_tready  = '0;
        m_core_tvalid = 1'b0;
        m_core_tdata  = '0;
        m_core_tkeep  = '0;
        m_core_tid    = '0;
        m_core_tlast  = 1'b0;
        case (state)
            IDLE: begin
                // A full FIFO blocks the grant even if a pop lands this cycle.
                if (|s_req_tvalid && !fifo_full) begin
                    grant_nxt  = pick;
                    rr_ptr_nxt = pick;
                    push       = 1'b1;
                    state_nxt  = PASS;
                end
            end
            PASS: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant == tag_t'(i)) begin
                        m_core_tvalid   = s_req_tvalid[i];
                        s_req_tready[i] = m_core_tready;
                        m_core_tdata    = s_req_tdata[i*DATA_W +: DATA_W];
                        m_core_tkeep    = s_req_tkeep[i*KEEP_W +: KEEP_W];
                        m_core_tid      = s_req_tid[i*ID_W +: ID_W];
                        m_core_tlast    = s_req_tlast[i];
                    end
                end
                if (m_core_tvalid && m_core_tready && m_core_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digest routing: the FIFO head names the owner of the returning digest.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) head_oh[i] = (head == tag_t'(i));
    end

    assign m_res_tvalid = (s_res_tvalid && !fifo_empty) ? head_oh : '0;
    assign s_res_tready = !fifo_empty && |(m_res_tready & head_oh);
    assign m_res_tdata  = fifo_empty ? '0 : s_res_tdata;
    assign pop          = s_res_tvalid && s_res_tready;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            err_orphan <= 1'b0;
        end else if (s_res_tvalid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef HMAC_ARB_STATS_EN
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (state == PASS && grant == tag_t'(i) && s_req_tvalid[i] &&
                    m_core_tready && s_req_tlast[i])
                    pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
            end
            if (state == IDLE && |s_req_tvalid && fifo_full && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
